// File: rtl/pad_sequencer.sv
// Keccak-512 pad sequencer: packs 32-bit message words into RATE_WORDS-word
// rate blocks, appending 0x01 / 0x80 multi-rate padding after the last word.
module pad_sequencer #(
  parameter int unsigned RATE_WORDS = 18
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [31:0]             in,
  input  logic                    in_ready,
  input  logic                    is_last,
  input  logic [1:0]              byte_num,
  input  logic                    f_ack,
  output logic                    buffer_full,
  output logic [32*RATE_WORDS-1:0] out,
  output logic                    out_ready
);

  localparam int unsigned CW = $clog2(RATE_WORDS + 1);
  localparam int unsigned OW = 32 * RATE_WORDS;
  localparam logic [CW-1:0] CNT_LAST = CW'(RATE_WORDS - 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_PAD     = 2'd1;
  localparam logic [1:0] S_FULL    = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          padded_q, padded_d;
  logic          full_q, full_d;
  logic [OW-1:0] out_q, out_d;
  logic [31:0]   last_word;
  logic [31:0]   w;
  logic          shift;

  // Final word: keep byte_num leading bytes, then the 0x01 pad-start byte.
  always_comb begin
    last_word = 32'h0100_0000;
    unique case (byte_num)
      2'd0:    last_word = 32'h0100_0000;
      2'd1:    last_word = {in[31:24], 24'h01_0000};
      2'd2:    last_word = {in[31:16], 16'h0100};
      default: last_word = {in[31:8], 8'h01};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    padded_d = padded_q;
    full_d   = full_q;
    out_d    = out_q;
    w        = '0;
    shift    = 1'b0;

    unique case (state_q)
      S_COLLECT: begin
        if (in_ready && !full_q) begin
          shift = 1'b1;
          if (is_last) begin
            padded_d = 1'b1;
            if (cnt_q == CNT_LAST) begin
              w = last_word | 32'h0000_0080;
            end else begin
              w       = last_word;
              state_d = S_PAD;
            end
          end else begin
            w = in;
          end
        end
      end
      S_PAD: begin
        shift = 1'b1;
        w     = (cnt_q == CNT_LAST) ? 32'h0000_0080 : 32'h0000_0000;
      end
      S_FULL: begin
        if (f_ack) begin
          cnt_d   = '0;
          full_d  = 1'b0;
          state_d = padded_q ? S_DONE : S_COLLECT;
        end
      end
      default: ;
    endcase

    // Filling the final slot overrides any PAD/COLLECT successor with FULL.
    if (shift) begin
      out_d = {out_q[OW-33:0], w};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = S_FULL;
        full_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_COLLECT;
      cnt_q    <= '0;
      padded_q <= 1'b0;
      full_q   <= 1'b0;
      out_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      padded_q <= padded_d;
      full_q   <= full_d;
      out_q    <= out_d;
    end
  end

  assign buffer_full = full_q;
  assign out_ready   = full_q;
  assign out         = out_q;

endmodule

// File: tb/tb_pad_sequencer.sv
// Bench for pad_sequencer: directed scenarios plus randomized traffic checked
// against a word-stream model (out = last RATE_WORDS words pushed).
module tb_pad_sequencer;

  localparam int RW = 18;
  localparam int OW = 32 * RW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   d_in = '0;
  logic          d_in_ready = 1'b0;
  logic          d_is_last = 1'b0;
  logic [1:0]    d_byte_num = '0;
  logic          d_f_ack = 1'b0;
  logic          buffer_full;
  logic [OW-1:0] out_w;
  logic          out_ready;

  int n_vec = 0;
  int n_err = 0;

  pad_sequencer #(.RATE_WORDS(RW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in         (d_in),
    .in_ready   (d_in_ready),
    .is_last    (d_is_last),
    .byte_num   (d_byte_num),
    .f_ack      (d_f_ack),
    .buffer_full(buffer_full),
    .out        (out_w),
    .out_ready  (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: history of words pushed, words in current block,
  // block-complete, message-ended and finished flags.
  logic [31:0] hist[$];
  int fill;
  bit m_full, m_done, m_ended;

  function automatic logic [31:0] pad_word(logic [31:0] x, int nb);
    logic [31:0] r;
    logic [7:0]  bv;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      if (b < nb)       bv = x[31-8*b -: 8];
      else if (b == nb) bv = 8'h01;
      else              bv = 8'h00;
      r[31-8*b -: 8] = bv;
    end
    return r;
  endfunction

  function automatic logic [OW-1:0] exp_out();
    logic [OW-1:0] r;
    int idx;
    r = '0;
    for (int i = 0; i < RW; i++) begin
      idx = hist.size() - RW + i;
      r = {r[OW-33:0], (idx >= 0) ? hist[idx] : 32'h0};
    end
    return r;
  endfunction

  task automatic model_reset();
    hist.delete();
    fill = 0;
    m_full = 0;
    m_done = 0;
    m_ended = 0;
  endtask

  task automatic model_edge();
    logic [31:0] w;
    if (!reset_n) begin model_reset(); return; end
    if (m_done) return;
    if (m_full) begin
      if (d_f_ack) begin m_full = 0; fill = 0; m_done = m_ended; end
      return;
    end
    if (m_ended) begin
      w = (fill == RW - 1) ? 32'h80 : 32'h0;
    end else if (d_in_ready) begin
      if (d_is_last) begin
        w = pad_word(d_in, int'(d_byte_num));
        m_ended = 1;
        if (fill == RW - 1) w = w | 32'h80;
      end else begin
        w = d_in;
      end
    end else begin
      return;
    end
    hist.push_back(w);
    if (hist.size() > RW) void'(hist.pop_front());
    fill++;
    if (fill == RW) m_full = 1;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    d_in_ready = 0; d_is_last = 0; d_f_ack = 0; d_byte_num = '0;
  endtask

  task automatic send(input logic [31:0] w, input logic last, input logic [1:0] bn);
    d_in = w; d_in_ready = 1; d_is_last = last; d_byte_num = bn;
    cycle();
    idle_inputs();
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (2) cycle();
    reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 0;
    model_reset();
    #3;
    n_vec++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL reset_bf got %0b exp 0", buffer_full); end
    n_vec++; if (out_ready !== 1'b0) begin n_err++; $display("FAIL reset_or got %0b exp 0", out_ready); end
    n_vec++; if (out_w !== '0) begin n_err++; $display("FAIL reset_out got %h exp 0", out_w); end
    repeat (2) cycle();
    reset_n = 1;
  endtask

  task automatic test_single_word();
    int n;
    do_reset();
    send(32'h90ABCDEF, 1, 2'd2);
    n = 0;
    while (buffer_full !== 1'b1 && n < 40) begin cycle(); n++; end
    n_vec++; if (n != 17) begin n_err++; $display("FAIL single_latency got %0d exp 17", n); end
    n_vec++; if (out_w[OW-1 -: 32] !== 32'h90AB0100) begin n_err++; $display("FAIL single_msw got %h exp 90ab0100", out_w[OW-1 -: 32]); end
    n_vec++; if (out_w[OW-33:32] !== '0) begin n_err++; $display("FAIL single_mid got %h exp 0", out_w[OW-33:32]); end
    n_vec++; if (out_w[31:0] !== 32'h80) begin n_err++; $display("FAIL single_lsw got %h exp 00000080", out_w[31:0]); end
    n_vec++; if (out_w !== exp_out()) begin n_err++; $display("FAIL single_model got %h exp %h", out_w, exp_out()); end
  endtask

  task automatic test_full_block();
    logic [OW-1:0] e;
    do_reset();
    e = '0;
    for (int i = 1; i <= RW; i++) begin
      send(32'(i), 0, 2'd0);
      e = {e[OW-33:0], 32'(i)};
    end
    n_vec++; if (buffer_full !== 1'b1 || out_ready !== 1'b1) begin n_err++; $display("FAIL full_bf got %0b/%0b exp 1/1", buffer_full, out_ready); end
    n_vec++; if (out_w !== e) begin n_err++; $display("FAIL full_out got %h exp %h", out_w, e); end
    d_f_ack = 1; cycle(); idle_inputs();
    n_vec++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL full_ack got %0b exp 0", buffer_full); end
    send(32'hDEADBEEF, 1, 2'd0);
    repeat (17) cycle();
    n_vec++; if (buffer_full !== 1'b1) begin n_err++; $display("FAIL full_pad_bf got %0b exp 1", buffer_full); end
    n_vec++; if (out_w[OW-1 -: 32] !== 32'h01000000) begin n_err++; $display("FAIL full_pad_msw got %h exp 01000000", out_w[OW-1 -: 32]); end
    n_vec++; if (out_w[31:0] !== 32'h80 || out_w[OW-33:32] !== '0) begin n_err++; $display("FAIL full_pad_rest got %h exp 0..080", out_w[OW-33:0]); end
  endtask

  task automatic test_last_at_end();
    logic [OW-1:0] saved;
    do_reset();
    for (int i = 0; i < RW - 1; i++) send($urandom, 0, 2'd0);
    send(32'h90ABCDEF, 1, 2'd3);
    n_vec++; if (buffer_full !== 1'b1) begin n_err++; $display("FAIL end_bf got %0b exp 1", buffer_full); end
    n_vec++; if (out_w[31:0] !== 32'h90ABCD81) begin n_err++; $display("FAIL end_lsw got %h exp 90abcd81", out_w[31:0]); end
    n_vec++; if (out_w !== exp_out()) begin n_err++; $display("FAIL end_model got %h exp %h", out_w, exp_out()); end
    saved = out_w;
    d_f_ack = 1; cycle(); idle_inputs();
    for (int i = 0; i < 6; i++) begin
      d_in = $urandom; d_in_ready = 1; d_is_last = i[0]; d_f_ack = i[1];
      cycle();
    end
    idle_inputs();
    n_vec++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL done_bf got %0b exp 0", buffer_full); end
    n_vec++; if (out_w !== saved) begin n_err++; $display("FAIL done_out got %h exp %h", out_w, saved); end
  endtask

  task automatic test_back_to_back();
    logic [OW-1:0] saved;
    do_reset();
    for (int i = 0; i < RW; i++) send($urandom, 0, 2'd0);
    saved = out_w;
    for (int i = 0; i < 3; i++) begin d_in = $urandom; d_in_ready = 1; cycle(); end
    n_vec++; if (out_w !== saved || buffer_full !== 1'b1) begin n_err++; $display("FAIL bp_hold got %h/%0b exp %h/1", out_w, buffer_full, saved); end
    d_in = 32'hA5A5A5A5; d_in_ready = 1; d_f_ack = 1; cycle(); idle_inputs();
    n_vec++; if (out_w !== saved || buffer_full !== 1'b0) begin n_err++; $display("FAIL bp_ackdrop got %h/%0b exp %h/0", out_w, buffer_full, saved); end
    send(32'h12345678, 0, 2'd0);
    n_vec++; if (out_w !== {saved[OW-33:0], 32'h12345678}) begin n_err++; $display("FAIL bp_first got %h exp %h", out_w, {saved[OW-33:0], 32'h12345678}); end
    for (int i = 1; i < RW - 1; i++) send($urandom, 0, 2'd0);
    n_vec++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL bp_cnt17 got %0b exp 0", buffer_full); end
    send($urandom, 0, 2'd0);
    n_vec++; if (buffer_full !== 1'b1) begin n_err++; $display("FAIL bp_cnt18 got %0b exp 1", buffer_full); end
    n_vec++; if (out_w !== exp_out()) begin n_err++; $display("FAIL bp_model got %h exp %h", out_w, exp_out()); end
  endtask

  task automatic test_async_reset();
    logic [OW-1:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) send(32'hF000_0000 + 32'(i), 0, 2'd0);
    #2 reset_n = 0;
    model_reset();
    #1;
    n_vec++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL arst_bf got %0b exp 0", buffer_full); end
    n_vec++; if (out_w !== '0) begin n_err++; $display("FAIL arst_out got %h exp 0", out_w); end
    #3 reset_n = 1;
    e = '0;
    for (int i = 0; i < RW; i++) begin
      send(32'h100 + 32'(i), 0, 2'd0);
      e = {e[OW-33:0], 32'h100 + 32'(i)};
      if (i == RW - 2) begin
        n_vec++; if (buffer_full !== 1'b0) begin n_err++; $display("FAIL arst_cnt17 got %0b exp 0", buffer_full); end
      end
    end
    n_vec++; if (buffer_full !== 1'b1) begin n_err++; $display("FAIL arst_bf18 got %0b exp 1", buffer_full); end
    n_vec++; if (out_w !== e) begin n_err++; $display("FAIL arst_block got %h exp %h", out_w, e); end
  endtask

  task automatic test_random();
    for (int m = 0; m < 6; m++) begin
      do_reset();
      for (int c = 0; c < 150; c++) begin
        d_in       = $urandom;
        d_in_ready = ($urandom_range(0, 3) != 0);
        d_is_last  = ($urandom_range(0, 24) == 0);
        d_byte_num = 2'($urandom_range(0, 3));
        d_f_ack    = ($urandom_range(0, 2) == 0);
        cycle();
        n_vec++; if (buffer_full !== m_full) begin n_err++; $display("FAIL rnd_bf m%0d c%0d got %0b exp %0b", m, c, buffer_full, m_full); end
        n_vec++; if (out_ready !== m_full) begin n_err++; $display("FAIL rnd_or m%0d c%0d got %0b exp %0b", m, c, out_ready, m_full); end
        n_vec++; if (out_w !== exp_out()) begin n_err++; $display("FAIL rnd_out m%0d c%0d got %h exp %h", m, c, out_w, exp_out()); end
      end
      idle_inputs();
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_full_block();
    test_last_at_end();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pad_sequencer.md
PAD_SEQUENCER -- requirements
Module: pad_sequencer

Interface
REQ-001 Parameter RATE_WORDS, default 18, meaning 32-bit words per rate block (576-bit Keccak-512 rate).
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in  input  32  message word, big-endian byte order, byte 0 = in[31:24].
REQ-005 in_ready  input  1  in, is_last and byte_num valid this cycle.
REQ-006 is_last  input  1  current word is the final message word.
REQ-007 byte_num  input  2  valid bytes in the final word (0..3); ignored unless is_last.
REQ-008 f_ack  input  1  one-cycle pulse: permutation has consumed out.
REQ-009 buffer_full  output  1  block complete; no word accepted this cycle.
REQ-010 out  output  32*RATE_WORDS  assembled block; first word at MSBs.
REQ-011 out_ready  output  1  out is valid for the permutation; equals buffer_full.

Function
REQ-012 States: COLLECT, PAD, FULL, DONE; word counter cnt 0..RATE_WORDS.
REQ-013 Accept: in_ready=1, state COLLECT, buffer_full=0 -> shift word in: out <= {out[MSB-32:0], w}, cnt+1.
REQ-014 in_ready while buffer_full=1 or in PAD/DONE: word dropped, no state change; upstream gates on buffer_full.
REQ-015 Non-last accepted word: w = in unchanged.
REQ-016 Last accepted word: w = first byte_num bytes of in, then byte 0x01, remaining bytes 0x00 (byte_num 0/1/2/3 with in=90ABCDEF -> 01000000/90010000/90AB0100/90ABCD01); state -> PAD, padded flag set.
REQ-017 Full-length message: last word with byte_num=0 carries no data (w=0x01000000).
REQ-018 PAD: one word per cycle, w = 0x00000000, except word index RATE_WORDS-1 which is w = 0x00000080.
REQ-019 If the last message word itself lands at index RATE_WORDS-1, it is ORed with 0x00000080 (byte_num=3 -> 90ABCD81); no extra block, PAD skipped.
REQ-020 cnt reaching RATE_WORDS -> state FULL, buffer_full=1 on the following cycle (registered); out stable while FULL.
REQ-021 FULL + f_ack -> cnt=0, buffer_full=0 next cycle; state COLLECT if padded flag clear, else DONE.
REQ-022 f_ack outside FULL ignored.
REQ-023 f_ack with in_ready in the same cycle while FULL: ack honoured, word dropped.
REQ-024 DONE: buffer_full=0, all inputs except reset_n ignored, out holds last block.
REQ-025 Latency: 18th accepted word at edge N -> buffer_full=1 after edge N; last word at index k<17 -> buffer_full=1 after 17-k further edges.
REQ-026 out bits not yet written in a block hold the previous block's shifted contents; only the complete block is valid when out_ready=1.

Reset
REQ-027 reset_n=0 asynchronously forces state COLLECT, cnt=0, padded=0, buffer_full=0, out_ready=0, out=0.
REQ-028 Reset mid-block or mid-PAD discards the partial block; the first word after release lands at index 0.
REQ-029 Reset release is sampled on the next rising edge; no accept on the release cycle unless reset_n high before that edge.

Verification
REQ-030 Reset, 1 word in=90ABCDEF is_last byte_num=2 -> after 17 PAD cycles buffer_full=1, out MSW=90AB0100, 16 zero words, LSW=00000080.
REQ-031 18 words 0x00000001..0x00000012 non-last -> buffer_full=1, out=0x00000001...00000012; f_ack -> buffer_full=0, state COLLECT, then is_last byte_num=0 -> block MSW=01000000, LSW=00000080.
REQ-032 17 non-last words then in=90ABCDEF is_last byte_num=3 -> single block, LSW=90ABCD81, after f_ack state DONE, further in_ready ignored.
REQ-033 in_ready held high while buffer_full=1 with new data -> out unchanged, cnt unchanged; f_ack and in_ready same cycle -> word dropped.
REQ-034 reset_n pulsed low between clock edges after 5 words -> buffer_full=0 and out=0 immediately; next 18 words form a clean block.
